mem_miss_requester: RTL and testbench
=====================================

Name: mem_miss_requester

Overview:
- Core-side initiator for the shared miss interface served by the testbench memory arbiter.
- Accepts one line-fill or writeback request from the I$ and one from the D$.
- Issues each request to memory as a one-cycle valid pulse with held request info.
- Routes the response back to the owning cache by cache id, and bounds each wait with a timeout so a lost response cannot hang the core.

Parameters:
- ADDR_WIDTH, 32, request address width.
- LINE_WIDTH, 128, cache line width; applies to request store data and response data.
- TIMEOUT_CYCLES, 256, maximum wait cycles per request before it is aborted; must be at least 2.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous active-low reset.
- ic_miss_valid_i  in  1  I$ presents a request.
- ic_miss_addr_i  in  ADDR_WIDTH  I$ request line address.
- ic_miss_ready_o  out  1  I$ request accepted this cycle when high together with ic_miss_valid_i.
- ic_fill_valid_o  out  1  one-cycle pulse: I$ response delivered.
- ic_fill_data_o  out  LINE_WIDTH  I$ response line data.
- ic_fill_error_o  out  1  bus error or timeout on the I$ request.
- dc_miss_valid_i  in  1  D$ presents a request.
- dc_miss_addr_i  in  ADDR_WIDTH  D$ request line address.
- dc_miss_is_store_i  in  1  D$ writeback when 1, line fill when 0.
- dc_miss_data_i  in  LINE_WIDTH  D$ writeback data.
- dc_miss_ready_o  out  1  D$ request accepted this cycle when high together with dc_miss_valid_i.
- dc_fill_valid_o  out  1  one-cycle pulse: D$ response delivered.
- dc_fill_data_o  out  LINE_WIDTH  D$ response line data.
- dc_fill_error_o  out  1  bus error or timeout on the D$ request.
- icache_req_valid_miss  out  1  one-cycle request pulse to memory for the I$.
- icache_req_addr_miss  out  ADDR_WIDTH  I$ request address to memory.
- dcache_req_valid_miss  out  1  one-cycle request pulse to memory for the D$.
- dcache_req_addr_miss  out  ADDR_WIDTH  D$ request address to memory.
- dcache_req_is_store_miss  out  1  D$ request type to memory.
- dcache_req_data_miss  out  LINE_WIDTH  D$ writeback data to memory.
- rsp_valid_miss  in  1  memory response valid.
- rsp_cache_id  in  1  response owner: 0 = I$, 1 = D$.
- rsp_data_miss  in  LINE_WIDTH  memory response line data.
- rsp_bus_error  in  1  memory response carries a bus error.
- spurious_rsp_o  out  1  sticky flag: a response arrived for a channel that was not waiting.

Behaviour:
- The I$ and D$ channels are independent; each runs the FSM below. At most one request is outstanding per channel, so at most two in total.
- FSM states: IDLE, ISSUE, WAIT, STALE. Reset state is IDLE on both channels.
- IDLE:
  - ready_o = 1.
  - On valid_i: capture addr, plus is_store and data for the D$, then go to ISSUE.
  - Ready depends only on state, not on valid_i.
- ISSUE:
  - ready_o = 0.
  - Assert req_valid for exactly one cycle, then go to WAIT.
  - Clear the timeout counter.
- WAIT:
  - ready_o = 0.
  - Request info outputs stay stable from the ISSUE cycle until the channel returns to IDLE.
  - On rsp_valid_miss with a matching rsp_cache_id, in the same cycle: fill_valid_o = 1, fill_data_o = rsp_data_miss, fill_error_o = rsp_bus_error. Next state is IDLE.
  - Otherwise increment the counter. If the counter equals TIMEOUT_CYCLES-1 and no response arrives that cycle: fill_valid_o = 1, fill_error_o = 1, fill_data_o = 0, next state STALE.
- STALE:
  - ready_o = 0.
  - Wait for the late matching response, discard it with no fill pulse, then go to IDLE.
  - Remains in STALE indefinitely if the response never arrives.
- Fill outputs are combinational from the response in WAIT. fill_data_o is 0 whenever fill_valid_o is 0.
- A matching response in IDLE or ISSUE sets spurious_rsp_o and is otherwise ignored. spurious_rsp_o clears only on reset.
- When a channel returns to IDLE, it can accept a new request in that IDLE cycle at the earliest, never in the fill cycle.
- Both channels may pulse req_valid in the same cycle; memory-side arbitration is not this block's concern.
- Reset: asynchronous. Both channels go to IDLE and the counters clear. After reset, ready_o = 1; all req_valid, fill_valid, fill_error and spurious outputs are 0; addr and data registers are 0. An in-flight request is dropped, and a response arriving after reset counts as spurious.
- Latency: accept at cycle N gives req_valid at N+1; the fill appears in the response cycle.
- Timeout counter width is $clog2(TIMEOUT_CYCLES); it counts WAIT cycles only.

Test Plan:
- Basic I$ fill: I$ request to addr 0x1000 → icache_req_valid_miss pulses for 1 cycle; response with cache_id = 0 and data 0xA5…A5 → ic_fill_valid_o pulses with that data, error = 0; ic_miss_ready_o is high again the next cycle.
- D$ store: addr 0x2000, data 0x1234 → dcache_req_is_store_miss = 1 and data is held through WAIT; response with cache_id = 1 → dc_fill_valid_o pulses with error = 0.
- Concurrency: both caches request in the same cycle → both req pulses appear together; D$ response precedes I$ response → each fill is routed to the correct channel, with no cross-delivery.
- Bus error: D$ load to 0xFFFF_0000, response with rsp_bus_error = 1 → dc_fill_error_o = 1 on the fill pulse.
- Timeout: TIMEOUT_CYCLES = 8 and no response → the fill pulse with error = 1 occurs 8 cycles after the req pulse; a late response is swallowed with no fill; ready_o returns to 1 the cycle after that response.
- Spurious response and reset: a response with cache_id = 0 while I$ is IDLE → spurious_rsp_o = 1 and stays 1. reset_i low while the D$ is in WAIT → all outputs return to reset values immediately; a later D$ response sets the spurious flag.

Source files
------------

// File: rtl/mem_miss_requester.sv
`default_nettype none
// ============================================================================
// Module   : mem_miss_requester
// Purpose  : Core-side initiator for the shared cache-miss memory interface.
//            Holds one outstanding line-fill/writeback request for the I$ and
//            one for the D$, issues each to memory as a one-cycle valid pulse
//            with held request info, routes responses back by cache id, and
//            aborts a request whose response does not arrive within
//            TIMEOUT_CYCLES wait cycles.
// Ports    :
//   clk_i, reset_i              clock, asynchronous active-low reset
//   ic_miss_*  / ic_fill_*      I$ request handshake and fill delivery
//   dc_miss_*  / dc_fill_*      D$ request handshake and fill delivery
//   icache_req_*_miss           I$ request to memory
//   dcache_req_*_miss           D$ request to memory
//   rsp_*                       memory response (rsp_cache_id: 0=I$, 1=D$)
//   spurious_rsp_o              sticky: response for a channel not waiting
// Revision : 1.0 - initial release
// ============================================================================
module mem_miss_requester #(
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    input  logic                  ic_miss_valid_i,
    input  logic [ADDR_WIDTH-1:0] ic_miss_addr_i,
    output logic                  ic_miss_ready_o,
    output logic                  ic_fill_valid_o,
    output logic [LINE_WIDTH-1:0] ic_fill_data_o,
    output logic                  ic_fill_error_o,

    input  logic                  dc_miss_valid_i,
    input  logic [ADDR_WIDTH-1:0] dc_miss_addr_i,
    input  logic                  dc_miss_is_store_i,
    input  logic [LINE_WIDTH-1:0] dc_miss_data_i,
    output logic                  dc_miss_ready_o,
    output logic                  dc_fill_valid_o,
    output logic [LINE_WIDTH-1:0] dc_fill_data_o,
    output logic                  dc_fill_error_o,

    output logic                  icache_req_valid_miss,
    output logic [ADDR_WIDTH-1:0] icache_req_addr_miss,
    output logic                  dcache_req_valid_miss,
    output logic [ADDR_WIDTH-1:0] dcache_req_addr_miss,
    output logic                  dcache_req_is_store_miss,
    output logic [LINE_WIDTH-1:0] dcache_req_data_miss,

    input  logic                  rsp_valid_miss,
    input  logic                  rsp_cache_id,
    input  logic [LINE_WIDTH-1:0] rsp_data_miss,
    input  logic                  rsp_bus_error,

    output logic                  spurious_rsp_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_STALE = 2'd3;

    // Response steering: each channel only reacts to its own cache id.
    logic ic_rsp_hit;
    logic dc_rsp_hit;
    assign ic_rsp_hit = rsp_valid_miss & ~rsp_cache_id;
    assign dc_rsp_hit = rsp_valid_miss &  rsp_cache_id;

    // ------------------------------------------------------------------------
    // I$ channel
    // ------------------------------------------------------------------------
    logic [1:0]            ic_state_q, ic_state_d;
    logic [CNT_W-1:0]      ic_cnt_q,   ic_cnt_d;
    logic [ADDR_WIDTH-1:0] ic_addr_q,  ic_addr_d;
    logic                  ic_spur_set;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ic_state_q <= c_ST_IDLE;
            ic_cnt_q   <= '0;
            ic_addr_q  <= '0;
        end else begin
            ic_state_q <= ic_state_d;
            ic_cnt_q   <= ic_cnt_d;
            ic_addr_q  <= ic_addr_d;
        end
    end

    always_comb begin
        ic_state_d = ic_state_q;
        ic_cnt_d   = ic_cnt_q;
        ic_addr_d  = ic_addr_q;
        case (ic_state_q)
            c_ST_IDLE: begin
                if (ic_miss_valid_i) begin
                    ic_addr_d  = ic_miss_addr_i;
                    ic_state_d = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                ic_cnt_d   = '0;
                ic_state_d = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (ic_rsp_hit) begin
                    ic_state_d = c_ST_IDLE;
                end else if (ic_cnt_q == c_CNT_LAST) begin
                    ic_state_d = c_ST_STALE;
                end else begin
                    ic_cnt_d = ic_cnt_q + 1'b1;
                end
            end
            c_ST_STALE: begin
                // Late response is swallowed; the cache already saw the error.
                if (ic_rsp_hit) begin
                    ic_state_d = c_ST_IDLE;
                end
            end
            default: ic_state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        ic_miss_ready_o       = 1'b0;
        icache_req_valid_miss = 1'b0;
        ic_fill_valid_o       = 1'b0;
        ic_fill_data_o        = '0;
        ic_fill_error_o       = 1'b0;
        ic_spur_set           = 1'b0;
        case (ic_state_q)
            c_ST_IDLE: begin
                ic_miss_ready_o = 1'b1;
                ic_spur_set     = ic_rsp_hit;
            end
            c_ST_ISSUE: begin
                icache_req_valid_miss = 1'b1;
                ic_spur_set           = ic_rsp_hit;
            end
            c_ST_WAIT: begin
                if (ic_rsp_hit) begin
                    ic_fill_valid_o = 1'b1;
                    ic_fill_data_o  = rsp_data_miss;
                    ic_fill_error_o = rsp_bus_error;
                end else if (ic_cnt_q == c_CNT_LAST) begin
                    ic_fill_valid_o = 1'b1;
                    ic_fill_error_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign icache_req_addr_miss = ic_addr_q;

    // ------------------------------------------------------------------------
    // D$ channel
    // ------------------------------------------------------------------------
    logic [1:0]            dc_state_q, dc_state_d;
    logic [CNT_W-1:0]      dc_cnt_q,   dc_cnt_d;
    logic [ADDR_WIDTH-1:0] dc_addr_q,  dc_addr_d;
    logic                  dc_store_q, dc_store_d;
    logic [LINE_WIDTH-1:0] dc_data_q,  dc_data_d;
    logic                  dc_spur_set;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            dc_state_q <= c_ST_IDLE;
            dc_cnt_q   <= '0;
            dc_addr_q  <= '0;
            dc_store_q <= 1'b0;
            dc_data_q  <= '0;
        end else begin
            dc_state_q <= dc_state_d;
            dc_cnt_q   <= dc_cnt_d;
            dc_addr_q  <= dc_addr_d;
            dc_store_q <= dc_store_d;
            dc_data_q  <= dc_data_d;
        end
    end

    always_comb begin
        dc_state_d = dc_state_q;
        dc_cnt_d   = dc_cnt_q;
        dc_addr_d  = dc_addr_q;
        dc_store_d = dc_store_q;
        dc_data_d  = dc_data_q;
        case (dc_state_q)
            c_ST_IDLE: begin
                if (dc_miss_valid_i) begin
                    dc_addr_d  = dc_miss_addr_i;
                    dc_store_d = dc_miss_is_store_i;
                    dc_data_d  = dc_miss_data_i;
                    dc_state_d = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                dc_cnt_d   = '0;
                dc_state_d = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (dc_rsp_hit) begin
                    dc_state_d = c_ST_IDLE;
                end else if (dc_cnt_q == c_CNT_LAST) begin
                    dc_state_d = c_ST_STALE;
                end else begin
                    dc_cnt_d = dc_cnt_q + 1'b1;
                end
            end
            c_ST_STALE: begin
                if (dc_rsp_hit) begin
                    dc_state_d = c_ST_IDLE;
                end
            end
            default: dc_state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        dc_miss_ready_o       = 1'b0;
        dcache_req_valid_miss = 1'b0;
        dc_fill_valid_o       = 1'b0;
        dc_fill_data_o        = '0;
        dc_fill_error_o       = 1'b0;
        dc_spur_set           = 1'b0;
        case (dc_state_q)
            c_ST_IDLE: begin
                dc_miss_ready_o = 1'b1;
                dc_spur_set     = dc_rsp_hit;
            end
            c_ST_ISSUE: begin
                dcache_req_valid_miss = 1'b1;
                dc_spur_set           = dc_rsp_hit;
            end
            c_ST_WAIT: begin
                if (dc_rsp_hit) begin
                    dc_fill_valid_o = 1'b1;
                    dc_fill_data_o  = rsp_data_miss;
                    dc_fill_error_o = rsp_bus_error;
                end else if (dc_cnt_q == c_CNT_LAST) begin
                    dc_fill_valid_o = 1'b1;
                    dc_fill_error_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign dcache_req_addr_miss     = dc_addr_q;
    assign dcache_req_is_store_miss = dc_store_q;
    assign dcache_req_data_miss     = dc_data_q;

    // ------------------------------------------------------------------------
    // Sticky spurious-response flag, cleared only by reset
    // ------------------------------------------------------------------------
    logic spurious_q, spurious_d;

    assign spurious_d = spurious_q | ic_spur_set | dc_spur_set;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            spurious_q <= 1'b0;
        end else begin
            spurious_q <= spurious_d;
        end
    end

    assign spurious_rsp_o = spurious_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_miss_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_miss_requester
// Purpose  : Directed self-checking bench for mem_miss_requester with
//            TIMEOUT_CYCLES = 8. Inputs change on the falling edge; outputs
//            are checked 1 ns later, away from the rising (active) edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_miss_requester;

    localparam int AW = 32;
    localparam int LW = 128;
    localparam int TO = 8;

    localparam logic [LW-1:0] c_A5 = {16{8'hA5}};
    localparam logic [LW-1:0] c_D0 = {4{32'h0D0D_0D0D}};
    localparam logic [LW-1:0] c_D1 = {4{32'hD1D1_D1D1}};
    localparam logic [LW-1:0] c_EE = {4{32'hEEEE_EEEE}};
    localparam logic [LW-1:0] c_LT = {4{32'h1A7E_1A7E}};

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ic_miss_valid_i = 1'b0;
    logic [AW-1:0] ic_miss_addr_i = '0;
    logic          ic_miss_ready_o;
    logic          ic_fill_valid_o;
    logic [LW-1:0] ic_fill_data_o;
    logic          ic_fill_error_o;
    logic          dc_miss_valid_i = 1'b0;
    logic [AW-1:0] dc_miss_addr_i = '0;
    logic          dc_miss_is_store_i = 1'b0;
    logic [LW-1:0] dc_miss_data_i = '0;
    logic          dc_miss_ready_o;
    logic          dc_fill_valid_o;
    logic [LW-1:0] dc_fill_data_o;
    logic          dc_fill_error_o;
    logic          icache_req_valid_miss;
    logic [AW-1:0] icache_req_addr_miss;
    logic          dcache_req_valid_miss;
    logic [AW-1:0] dcache_req_addr_miss;
    logic          dcache_req_is_store_miss;
    logic [LW-1:0] dcache_req_data_miss;
    logic          rsp_valid_miss = 1'b0;
    logic          rsp_cache_id = 1'b0;
    logic [LW-1:0] rsp_data_miss = '0;
    logic          rsp_bus_error = 1'b0;
    logic          spurious_rsp_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_miss_requester #(
        .ADDR_WIDTH    (AW),
        .LINE_WIDTH    (LW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i                   (clk),
        .reset_i                 (reset_n),
        .ic_miss_valid_i         (ic_miss_valid_i),
        .ic_miss_addr_i          (ic_miss_addr_i),
        .ic_miss_ready_o         (ic_miss_ready_o),
        .ic_fill_valid_o         (ic_fill_valid_o),
        .ic_fill_data_o          (ic_fill_data_o),
        .ic_fill_error_o         (ic_fill_error_o),
        .dc_miss_valid_i         (dc_miss_valid_i),
        .dc_miss_addr_i          (dc_miss_addr_i),
        .dc_miss_is_store_i      (dc_miss_is_store_i),
        .dc_miss_data_i          (dc_miss_data_i),
        .dc_miss_ready_o         (dc_miss_ready_o),
        .dc_fill_valid_o         (dc_fill_valid_o),
        .dc_fill_data_o          (dc_fill_data_o),
        .dc_fill_error_o         (dc_fill_error_o),
        .icache_req_valid_miss   (icache_req_valid_miss),
        .icache_req_addr_miss    (icache_req_addr_miss),
        .dcache_req_valid_miss   (dcache_req_valid_miss),
        .dcache_req_addr_miss    (dcache_req_addr_miss),
        .dcache_req_is_store_miss(dcache_req_is_store_miss),
        .dcache_req_data_miss    (dcache_req_data_miss),
        .rsp_valid_miss          (rsp_valid_miss),
        .rsp_cache_id            (rsp_cache_id),
        .rsp_data_miss           (rsp_data_miss),
        .rsp_bus_error           (rsp_bus_error),
        .spurious_rsp_o          (spurious_rsp_o)
    );

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge (inputs for the coming rising edge are
    // applied after this returns).
    task automatic nedge();
        @(negedge clk);
    endtask

    task automatic rsp(input logic v, input logic id, input logic [LW-1:0] d, input logic err);
        rsp_valid_miss = v;
        rsp_cache_id   = id;
        rsp_data_miss  = d;
        rsp_bus_error  = err;
    endtask

    initial begin
        // ---------------- reset state ----------------
        nedge();
        #1;
        chk("rst_ic_ready", ic_miss_ready_o, 1);
        chk("rst_dc_ready", dc_miss_ready_o, 1);
        chk("rst_ic_req",   icache_req_valid_miss, 0);
        chk("rst_dc_req",   dcache_req_valid_miss, 0);
        chk("rst_spur",     spurious_rsp_o, 0);
        chk("rst_dc_addr",  dcache_req_addr_miss, 0);
        chk("rst_dc_data",  dcache_req_data_miss, 0);
        nedge();
        reset_n = 1'b1;

        // ---------------- basic I$ fill ----------------
        nedge();
        ic_miss_valid_i = 1'b1;
        ic_miss_addr_i  = 32'h0000_1000;
        #1;
        chk("t1_ready_idle", ic_miss_ready_o, 1);
        nedge();
        ic_miss_valid_i = 1'b0;
        ic_miss_addr_i  = 32'hDEAD_BEEF;
        #1;
        chk("t1_req_pulse", icache_req_valid_miss, 1);
        chk("t1_req_addr",  icache_req_addr_miss, 32'h0000_1000);
        chk("t1_ready_iss", ic_miss_ready_o, 0);
        nedge();
        #1;
        chk("t1_req_1cyc",  icache_req_valid_miss, 0);
        chk("t1_addr_held", icache_req_addr_miss, 32'h0000_1000);
        rsp(1'b1, 1'b0, c_A5, 1'b0);
        #1;
        chk("t1_fill_v",    ic_fill_valid_o, 1);
        chk("t1_fill_d",    ic_fill_data_o, c_A5);
        chk("t1_fill_e",    ic_fill_error_o, 0);
        chk("t1_ready_fill", ic_miss_ready_o, 0);
        chk("t1_no_dc",     dc_fill_valid_o, 0);
        nedge();
        rsp(1'b0, 1'b0, '0, 1'b0);
        #1;
        chk("t1_ready_back", ic_miss_ready_o, 1);
        chk("t1_fill_off",  ic_fill_valid_o, 0);
        chk("t1_data_zero", ic_fill_data_o, 0);

        // ---------------- D$ store ----------------
        nedge();
        dc_miss_valid_i    = 1'b1;
        dc_miss_addr_i     = 32'h0000_2000;
        dc_miss_is_store_i = 1'b1;
        dc_miss_data_i     = 128'h1234;
        nedge();
        dc_miss_valid_i    = 1'b0;
        dc_miss_is_store_i = 1'b0;
        dc_miss_data_i     = c_EE;
        #1;
        chk("t2_req_pulse", dcache_req_valid_miss, 1);
        chk("t2_addr",      dcache_req_addr_miss, 32'h0000_2000);
        chk("t2_store",     dcache_req_is_store_miss, 1);
        chk("t2_data",      dcache_req_data_miss, 128'h1234);
        nedge();
        nedge();
        #1;
        chk("t2_req_off",    dcache_req_valid_miss, 0);
        chk("t2_store_held", dcache_req_is_store_miss, 1);
        chk("t2_data_held",  dcache_req_data_miss, 128'h1234);
        rsp(1'b1, 1'b1, c_D1, 1'b0);
        #1;
        chk("t2_fill_v", dc_fill_valid_o, 1);
        chk("t2_fill_e", dc_fill_error_o, 0);
        chk("t2_no_ic",  ic_fill_valid_o, 0);
        nedge();
        rsp(1'b0, 1'b0, '0, 1'b0);
        #1;
        chk("t2_ready_back", dc_miss_ready_o, 1);

        // ---------------- concurrency ----------------
        nedge();
        ic_miss_valid_i    = 1'b1;
        ic_miss_addr_i     = 32'h0000_3000;
        dc_miss_valid_i    = 1'b1;
        dc_miss_addr_i     = 32'h0000_4000;
        dc_miss_is_store_i = 1'b0;
        nedge();
        ic_miss_valid_i = 1'b0;
        dc_miss_valid_i = 1'b0;
        #1;
        chk("t3_ic_req", icache_req_valid_miss, 1);
        chk("t3_dc_req", dcache_req_valid_miss, 1);
        nedge();
        rsp(1'b1, 1'b1, c_D1, 1'b0);
        #1;
        chk("t3_dc_fill_v", dc_fill_valid_o, 1);
        chk("t3_dc_fill_d", dc_fill_data_o, c_D1);
        chk("t3_ic_quiet",  ic_fill_valid_o, 0);
        chk("t3_ic_data0",  ic_fill_data_o, 0);
        nedge();
        rsp(1'b1, 1'b0, c_D0, 1'b0);
        #1;
        chk("t3_ic_fill_v", ic_fill_valid_o, 1);
        chk("t3_ic_fill_d", ic_fill_data_o, c_D0);
        chk("t3_dc_quiet",  dc_fill_valid_o, 0);
        chk("t3_dc_ready",  dc_miss_ready_o, 1);
        nedge();
        rsp(1'b0, 1'b0, '0, 1'b0);
        #1;
        chk("t3_no_spur", spurious_rsp_o, 0);

        // ---------------- D$ bus error ----------------
        dc_miss_valid_i = 1'b1;
        dc_miss_addr_i  = 32'hFFFF_0000;
        nedge();
        dc_miss_valid_i = 1'b0;
        #1;
        chk("t4_addr", dcache_req_addr_miss, 32'hFFFF_0000);
        nedge();
        rsp(1'b1, 1'b1, c_EE, 1'b1);
        #1;
        chk("t4_fill_v", dc_fill_valid_o, 1);
        chk("t4_fill_e", dc_fill_error_o, 1);
        chk("t4_fill_d", dc_fill_data_o, c_EE);
        nedge();
        rsp(1'b0, 1'b0, '0, 1'b0);

        // ---------------- I$ timeout ----------------
        ic_miss_valid_i = 1'b1;
        ic_miss_addr_i  = 32'h0000_6000;
        nedge();
        ic_miss_valid_i = 1'b0;
        #1;
        chk("t5_req_pulse", icache_req_valid_miss, 1);
        for (int k = 1; k < TO; k++) begin
            nedge();
            #1;
            chk($sformatf("t5_wait_%0d", k), ic_fill_valid_o, 0);
        end
        nedge();
        #1;
        chk("t5_to_v", ic_fill_valid_o, 1);
        chk("t5_to_e", ic_fill_error_o, 1);
        chk("t5_to_d", ic_fill_data_o, 0);
        nedge();
        #1;
        chk("t5_stale_v",  ic_fill_valid_o, 0);
        chk("t5_stale_rdy", ic_miss_ready_o, 0);
        nedge();
        nedge();
        rsp(1'b1, 1'b0, c_LT, 1'b0);
        #1;
        chk("t5_late_v",   ic_fill_valid_o, 0);
        chk("t5_late_d",   ic_fill_data_o, 0);
        chk("t5_late_rdy", ic_miss_ready_o, 0);
        nedge();
        rsp(1'b0, 1'b0, '0, 1'b0);
        #1;
        chk("t5_ready_back", ic_miss_ready_o, 1);
        chk("t5_no_spur",    spurious_rsp_o, 0);

        // ---------------- spurious response ----------------
        rsp(1'b1, 1'b0, c_D0, 1'b0);
        #1;
        chk("t6_fill_idle", ic_fill_valid_o, 0);
        nedge();
        rsp(1'b0, 1'b0, '0, 1'b0);
        #1;
        chk("t6_spur_set", spurious_rsp_o, 1);
        nedge();
        #1;
        chk("t6_spur_sticky", spurious_rsp_o, 1);

        // ---------------- reset during D$ WAIT ----------------
        dc_miss_valid_i    = 1'b1;
        dc_miss_addr_i     = 32'h0000_5000;
        dc_miss_is_store_i = 1'b1;
        dc_miss_data_i     = c_D0;
        nedge();
        dc_miss_valid_i = 1'b0;
        nedge();
        #1;
        chk("t7_in_wait", dc_miss_ready_o, 0);
        reset_n = 1'b0;
        #1;
        chk("t7_rst_ready", dc_miss_ready_o, 1);
        chk("t7_rst_addr",  dcache_req_addr_miss, 0);
        chk("t7_rst_data",  dcache_req_data_miss, 0);
        chk("t7_rst_store", dcache_req_is_store_miss, 0);
        chk("t7_rst_spur",  spurious_rsp_o, 0);
        nedge();
        reset_n = 1'b1;
        nedge();
        rsp(1'b1, 1'b1, c_D1, 1'b0);
        #1;
        chk("t7_late_nofill", dc_fill_valid_o, 0);
        nedge();
        rsp(1'b0, 1'b0, '0, 1'b0);
        #1;
        chk("t7_late_spur", spurious_rsp_o, 1);

        nedge();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
